// File: rtl/breakout_vga_pkg.sv
// Timing constants and lock-state type shared by the VGA renderer and the
// sync decoder, so both ends of the link agree on 800x600@60.
package breakout_vga_pkg;

    localparam int   VGA_H_VISIBLE   = 800;
    localparam int   VGA_H_SYNC      = 128;
    localparam int   VGA_H_BACK      = 88;
    localparam int   VGA_H_TOTAL     = 1056;
    localparam int   VGA_V_VISIBLE   = 600;
    localparam int   VGA_V_SYNC      = 4;
    localparam int   VGA_V_BACK      = 23;
    localparam int   VGA_V_TOTAL     = 628;
    localparam logic VGA_SYNC_ACTIVE = 1'b1;
    localparam int   VGA_LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        LOCK_HUNT   = 2'd0,
        LOCK_CHECK  = 2'd1,
        LOCK_LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vga_lock_fsm.sv
// Lock tracker for the sync decoder: HUNT for a frame edge, CHECK a run of
// clean frames, then hold LOCKED until the first timing error.
module vga_lock_fsm
    import breakout_vga_pkg::*;
#(
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_err,
    input  logic        frame_err,
    input  logic        frame_edge,
    output logic        locked,
    output logic        err_inc,
    output lock_state_e state_next
);

    localparam int CNT_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic             any_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCK_HUNT;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_inc = 1'b0;
        any_err = line_err | frame_err;
        case (state_q)
            LOCK_HUNT: begin
                if (frame_edge) begin
                    state_d = LOCK_CHECK;
                    good_d  = '0;
                end
            end
            LOCK_CHECK: begin
                // An error on the edge that would complete lock wins.
                if (any_err) begin
                    state_d = LOCK_HUNT;
                end else if (frame_edge) begin
                    good_d = good_q + CNT_W'(1);
                    if (good_q + CNT_W'(1) == CNT_W'(LOCK_FRAMES)) begin
                        state_d = LOCK_LOCKED;
                    end
                end
            end
            LOCK_LOCKED: begin
                if (any_err) begin
                    state_d = LOCK_HUNT;
                    err_inc = 1'b1;
                end
            end
            default: state_d = LOCK_HUNT;
        endcase
    end

    assign locked     = (state_q == LOCK_LOCKED);
    assign state_next = state_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: registers the renderer's sync/colour stream,
// recovers pixel coordinates from sync timing and emits validated pixels.
module vga_sync_decoder
    import breakout_vga_pkg::*;
#(
    parameter int   H_VISIBLE   = VGA_H_VISIBLE,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   H_TOTAL     = VGA_H_TOTAL,
    parameter int   V_VISIBLE   = VGA_V_VISIBLE,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter int   V_TOTAL     = VGA_V_TOTAL,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic [7:0] COLOR,
    output logic       PIXEL_VALID,
    output logic [9:0] PIXEL_X,
    output logic [9:0] PIXEL_Y,
    output logic [7:0] PIXEL_COLOR,
    output logic       FRAME_START,
    output logic       LOCKED,
    output logic [7:0] ERR_COUNT
);

    localparam logic [10:0] H_MAX   = 11'h7FF;
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0]  V_MAX   = 10'h3FF;
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);

    // s1 input stage
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic [7:0]  color_s1_q, color_s1_d;

    // decode state
    logic        hs_prev_q, hs_prev_d;
    logic        vs_at_lead_q, vs_at_lead_d;
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;

    // output stage
    logic        valid_q, valid_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  color_q, color_d;
    logic        fs_q, fs_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        hs_act, vs_act, hs_lead, frame_edge;
    logic        line_err, frame_err, in_window;
    logic [10:0] h_off;
    logic [9:0]  v_off;
    logic        locked, err_inc;
    lock_state_e lock_state_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hs_s1_q      <= ~SYNC_ACTIVE;
            vs_s1_q      <= ~SYNC_ACTIVE;
            color_s1_q   <= '0;
            hs_prev_q    <= ~SYNC_ACTIVE;
            vs_at_lead_q <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            fs_q         <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            color_s1_q   <= color_s1_d;
            hs_prev_q    <= hs_prev_d;
            vs_at_lead_q <= vs_at_lead_d;
            h_q          <= h_d;
            v_q          <= v_d;
            valid_q      <= valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            fs_q         <= fs_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        hs_s1_d    = HSYNC;
        vs_s1_d    = VSYNC;
        color_s1_d = COLOR;
        hs_prev_d  = hs_s1_q;

        hs_act     = (hs_s1_q == SYNC_ACTIVE);
        vs_act     = (vs_s1_q == SYNC_ACTIVE);
        hs_lead    = hs_act && (hs_prev_q != SYNC_ACTIVE);
        // A frame edge is the first HSYNC edge seen with VSYNC active.
        frame_edge = hs_lead && vs_act && !vs_at_lead_q;

        vs_at_lead_d = hs_lead ? vs_act : vs_at_lead_q;

        if (hs_lead)            h_d = '0;
        else if (h_q == H_MAX)  h_d = h_q;
        else                    h_d = h_q + 11'd1;

        if (!hs_lead)           v_d = v_q;
        else if (frame_edge)    v_d = '0;
        else if (v_q == V_MAX)  v_d = v_q;
        else                    v_d = v_q + 10'd1;

        // Saturation is reported only on the sample that reaches the limit.
        line_err  = (hs_lead && (h_q != H_LAST)) || ((h_d == H_MAX) && (h_q != H_MAX));
        frame_err = (frame_edge && (v_q != V_LAST)) || ((v_d == V_MAX) && (v_q != V_MAX));

        in_window = (h_d >= H_START) && (h_d < H_END) && (v_d >= V_START) && (v_d < V_END);
        h_off     = h_d - H_START;
        v_off     = v_d - V_START;

        valid_d = (lock_state_next == LOCK_LOCKED) && in_window;
        x_d     = valid_d ? h_off[9:0] : x_q;
        y_d     = valid_d ? v_off : y_q;
        color_d = valid_d ? color_s1_q : color_q;
        fs_d    = valid_d && (h_off == 11'd0) && (v_off == 10'd0);

        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    vga_lock_fsm #(
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_lock_fsm (
        .clk        (CLK),
        .rst_n      (RST_N),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .frame_edge (frame_edge),
        .locked     (locked),
        .err_inc    (err_inc),
        .state_next (lock_state_next)
    );

    assign PIXEL_VALID = valid_q;
    assign PIXEL_X     = x_q;
    assign PIXEL_Y     = y_q;
    assign PIXEL_COLOR = color_q;
    assign FRAME_START = fs_q;
    assign LOCKED      = locked;
    assign ERR_COUNT   = err_cnt_q;

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

- Receive-side counterpart of the game's VGA output: consumes the 8-bit `COLOR`, `HSYNC`, `VSYNC` stream the renderer drives, and recovers pixel coordinates from sync timing alone.
- Checks 800x600@60 timing (40 MHz pixel clock), tracks lock, and emits one validated pixel per clock.
- Used as an in-system display monitor and as the self-checking sink in renderer benches.
- Runs in the `CLK` domain, the same domain as the renderer.

## Interface
Parameters:
- `H_VISIBLE`, 800, visible pixels per line
- `H_SYNC`, 128, HSYNC width in clocks
- `H_BACK`, 88, back porch in clocks
- `H_TOTAL`, 1056, clocks per line
- `V_VISIBLE`, 600, visible lines
- `V_SYNC`, 4, VSYNC width in lines
- `V_BACK`, 23, back porch in lines
- `V_TOTAL`, 628, lines per frame
- `SYNC_ACTIVE`, 1'b1, active level of both syncs
- `LOCK_FRAMES`, 2, consecutive good frames required for lock

Ports:
- `CLK` in 1: pixel clock, 40 MHz
- `RST_N` in 1: reset; asynchronous assert, active-low
- `HSYNC` in 1: horizontal sync from the renderer
- `VSYNC` in 1: vertical sync from the renderer
- `COLOR` in 8: pixel colour
- `PIXEL_VALID` out 1: the current outputs describe a visible pixel, and the decoder is locked
- `PIXEL_X` out 10: column, 0..799
- `PIXEL_Y` out 10: row, 0..599
- `PIXEL_COLOR` out 8: sampled colour
- `FRAME_START` out 1: one-cycle pulse coincident with the valid pixel (0,0)
- `LOCKED` out 1: timing lock status
- `ERR_COUNT` out 8: timing errors seen while locked; saturates at 255

## Operation
Input sampling:
- `HSYNC`, `VSYNC` and `COLOR` are registered once (stage s1).
- All decoding uses s1 values only.

Horizontal position `h` (11 bits):
- The s1 sample in which HSYNC first becomes active (leading edge) has h=0.
- h increments on each later sample and saturates at 2047.

Vertical position `v` (10 bits):
- v updates only on an HSYNC leading edge.
- If VSYNC is active at that edge and was inactive at the previous HSYNC leading edge, v=0. This is a frame edge.
- Otherwise v increments, saturating at 1023.

Visible window:
- Horizontal: h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE), i.e. 216..1015.
- Vertical: v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE), i.e. 27..626.
- Coordinates: `PIXEL_X` = h−216, `PIXEL_Y` = v−27.

Errors:
- Line error: an HSYNC leading edge arrives with previous h ≠ H_TOTAL−1 (1055), or h reaches 2047.
- Frame error: a frame edge arrives with previous v ≠ V_TOTAL−1 (627), or v reaches 1023.

Lock state machine:
- HUNT:
  - Ignores errors.
  - At the first frame edge, clears the good-frame count and goes to CHECK.
- CHECK:
  - Any error → HUNT.
  - A frame edge with no error since the previous frame edge increments the good-frame count.
  - When the count reaches LOCK_FRAMES → LOCKED.
- LOCKED:
  - Any error → HUNT, and `ERR_COUNT` increments (saturating).
  - Several errors in the same cycle count once.

Outputs:
- `LOCKED` is high only in the LOCKED state.
- `PIXEL_VALID` = LOCKED and the sample is in the visible window.
- `PIXEL_X`, `PIXEL_Y` and `PIXEL_COLOR` hold their last values when not valid.
- `ERR_COUNT` is cleared only by reset.

## Timing
Reset:
- All outputs are 0.
- State HUNT, h=0, v=0, s1 registers cleared to the inactive sync level.

Latency:
- Exactly 2 clocks from input pins to outputs: s1 register, then output register.
- The transition into LOCKED is visible on `LOCKED` in the same output cycle as the frame-edge sample that caused it.

Error reporting:
- An error drops `LOCKED` and `PIXEL_VALID` in the output cycle of the offending sample.
- An error on the frame edge that would complete lock prevents lock; the state goes to HUNT.

Reset mid-frame:
- Output is immediately quiet.
- Re-lock requires a new frame edge followed by LOCK_FRAMES good frames.

## Structure
- Timing constants (H_*, V_*, visible start offsets) live in a shared `breakout_vga_pkg`, also imported by the renderer, so the two ends cannot disagree.
- The lock FSM state enum also lives in that package.
- One sub-module, `vga_lock_fsm`:
  - Inputs: line error, frame error, frame edge.
  - Outputs: `LOCKED`, error increment.
- Counters and windowing stay in the top module.

## Test plan
- Ideal 800x600@60 stream, `COLOR` = PIXEL_X[7:0]:
  - `LOCKED` rises at the frame edge that completes the 2nd full frame after the first edge.
  - `FRAME_START` then pulses with X=0, Y=0, COLOR=0x00.
  - Pixel (799, 599) appears with COLOR=0x1F.
  - 480000 valid pixels per frame.
- While locked, one line of 1054 clocks:
  - `LOCKED` and `PIXEL_VALID` drop at that HSYNC edge; `ERR_COUNT`=1.
  - Re-lock after 2 further good frames.
- While locked, a frame of 627 lines:
  - Frame error, `ERR_COUNT`+1, HUNT.
  - A 626-line frame during CHECK gives no count increment.
- HSYNC held inactive for 3000 clocks while locked:
  - Timeout at h=2047 drops lock exactly once; `ERR_COUNT`+1.
- 300 forced errors, each followed by a re-lock:
  - `ERR_COUNT` saturates at 255, no wrap.
- `RST_N` pulsed mid-line while locked:
  - All outputs 0 within the reset.
  - `ERR_COUNT`=0.
  - `LOCKED` returns only after a new edge plus 2 good frames.
